dsp_mac_sequencer: RTL

Sequencer that drives one DSP48A1-style multiply-accumulate slice to compute an N-term signed dot product, sum(a[i]*b[i]), over a valid/ready operand stream. It sits between a requester and the slice. It owns the slice's data inputs, clock enables, opmode and reset, and returns the 48-bit accumulated result on a valid/ready output port. The slice must be built with A0REG=0, B0REG=0, A1REG=1, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, CARRYINSEL="OPMODE5" and B_INPUT="DIRECT".

---
 rtl/dsp_mac_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer
//   Drives one DSP48A1-style MAC slice (A1/B1/M/P/OPMODE registered) to form a
//   signed N-term dot product over a valid/ready operand stream and returns
//   the 48-bit P value on a valid/ready result port.
//
//   Optional feature macro: DSP_MAC_NEG_EN adds cfg_neg (latched with start);
//   when set, opmode bit 7 selects subtract so the result is -sum mod 2^48.
//
// Ports
//   clk, rstn                  clock, async active-low reset
//   start, cfg_len[, cfg_neg]  job request (sampled in IDLE only)
//   busy                       state != IDLE
//   in_valid/in_ready/in_a/in_b  operand stream
//   out_valid/out_ready/out_data result stream
//   dsp_a, dsp_b               slice A/B (pass-through of in_a/in_b)
//   dsp_opmode, dsp_ce*        slice opmode and clock enables
//   dsp_rst                    slice reset (high during reset + 1 clock)
//   dsp_p                      slice P output
module dsp_mac_sequencer #(
   parameter int unsigned LEN_W = 10
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic [LEN_W-1:0] cfg_len,
`ifdef DSP_MAC_NEG_EN
   input  logic             cfg_neg,
`endif
   output logic             busy,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [17:0]      in_a,
   input  logic [17:0]      in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [47:0]      out_data,
   output logic [17:0]      dsp_a,
   output logic [17:0]      dsp_b,
   output logic [7:0]       dsp_opmode,
   output logic             dsp_cea,
   output logic             dsp_ceb,
   output logic             dsp_cem,
   output logic             dsp_cep,
   output logic             dsp_ceopmode,
   output logic             dsp_rst,
   input  logic [47:0]      dsp_p
);

   localparam int unsigned P_W   = 48;
   localparam int unsigned OPM_W = 8;

   // Low nibble of opmode: X=M with Z=0 for the first term, Z=P afterwards
   localparam logic [3:0] OPM_FIRST = 4'h1;
   localparam logic [3:0] OPM_ACC   = 4'h9;

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

   state_t             state_q, state_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic               first_q, first_d;
   logic [OPM_W-1:0]   opmode_d;
   logic [P_W-1:0]     out_data_d;
   logic               v1_q, v2_q;
   logic               accept_c;
   logic               neg_q;
`ifdef DSP_MAC_NEG_EN
   logic               neg_d;
`else
   assign neg_q = 1'b0;
`endif

   // Operands go straight to the slice; its A1/B1 registers capture them on accept
   assign dsp_a        = in_a;
   assign dsp_b        = in_b;
   assign accept_c     = in_valid & in_ready;
   assign dsp_cea      = accept_c;
   assign dsp_ceb      = accept_c;
   assign dsp_cem      = v1_q;
   assign dsp_cep      = v2_q;
   assign dsp_ceopmode = 1'b1;

   // Next-state and datapath-next logic
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      first_d    = first_q;
      opmode_d   = dsp_opmode;
      out_data_d = out_data;
`ifdef DSP_MAC_NEG_EN
      neg_d      = neg_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               if (cfg_len != '0) begin
                  cnt_d   = cfg_len;
                  first_d = 1'b1;
`ifdef DSP_MAC_NEG_EN
                  neg_d   = cfg_neg;
`endif
                  state_d = LOAD;
               end else begin
                  out_data_d = '0;
                  state_d    = DONE;
               end
            end
         end
         LOAD: begin
            if (accept_c) begin
               cnt_d    = cnt_q - LEN_W'(1);
               first_d  = 1'b0;
               opmode_d = {neg_q, 3'b000, (first_q ? OPM_FIRST : OPM_ACC)};
               if (cnt_q == LEN_W'(1)) state_d = DRAIN;
            end
         end
         DRAIN: begin
            // cnt is 0 on entry; the third edge sees P holding the final sum
            if (cnt_q == LEN_W'(2)) begin
               out_data_d = dsp_p;
               cnt_d      = '0;
               state_d    = DONE;
            end else begin
               cnt_d = cnt_q + LEN_W'(1);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         first_q    <= 1'b0;
         v1_q       <= 1'b0;
         v2_q       <= 1'b0;
         dsp_opmode <= '0;
         out_data   <= '0;
         busy       <= 1'b0;
         in_ready   <= 1'b0;
         out_valid  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         first_q    <= first_d;
         v1_q       <= accept_c;
         v2_q       <= v1_q;
         dsp_opmode <= opmode_d;
         out_data   <= out_data_d;
         busy       <= (state_d != IDLE);
         in_ready   <= (state_d == LOAD);
         out_valid  <= (state_d == DONE);
      end
   end

`ifdef DSP_MAC_NEG_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) neg_q <= 1'b0;
      else       neg_q <= neg_d;
   end
`endif

   // Slice reset: held through reset and one clock beyond release
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) dsp_rst <= 1'b1;
      else       dsp_rst <= 1'b0;
   end

endmodule
